ysyx_24090012_idu: RTL and testbench

Instruction decode stage of the single-issue NPC core, directly downstream of the IFU. Accepts one 32-bit instruction plus its PC per valid/ready handshake from the IFU, decodes it into a registered control/operand bundle, and presents that bundle to the EXU through a second valid/ready handshake. A halt state machine stops intake after `ebreak` or an illegal instruction.

---
 rtl/ysyx_24090012_idu_pkg.sv | 92 +++++++++
 rtl/ysyx_24090012_imm_gen.sv | 31 +++
 rtl/ysyx_24090012_idu.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ysyx_24090012_idu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090012_idu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24090012_idu_pkg
// Shared definitions for the instruction decode stage:
//   - XLEN datapath width
//   - RV32I major opcode constants and the ebreak encoding
//   - ALU operation enum, immediate-type enum, stage FSM state enum
//   - idu_bundle_t: the registered control/operand bundle handed to the EXU
//   - alu_from_funct3(): maps funct3 (+ alternate bit) to an ALU operation
// ---------------------------------------------------------------------------
package ysyx_24090012_idu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } idu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            alu_src_imm;
        logic            alu_src_pc;
        logic [2:0]      funct3;
        logic            mem_ren;
        logic            mem_wen;
        logic            rd_wen;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic            is_ebreak;
        logic            illegal;
    } idu_bundle_t;

    // alt selects SUB over ADD (funct3=000) and SRA over SRL (funct3=101);
    // the caller decides when the alternate bit is meaningful.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ysyx_24090012_imm_gen.sv
// ---------------------------------------------------------------------------
// ysyx_24090012_imm_gen
// Combinational immediate extraction for RV32I formats.
//   inst_hi  in  25  instruction bits [31:7] (opcode field is not needed)
//   imm_type in  3   imm_type_e selector
//   imm      out XLEN sign-extended immediate (0 for IMM_NONE)
// All formats sign-extend from instruction bit 31.
// ---------------------------------------------------------------------------
module ysyx_24090012_imm_gen
    import ysyx_24090012_idu_pkg::*;
(
    input  logic [31:7]     inst_hi,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = XLEN'($signed(inst_hi[31:20]));
            IMM_S:   imm = XLEN'($signed({inst_hi[31:25], inst_hi[11:7]}));
            IMM_B:   imm = XLEN'($signed({inst_hi[31], inst_hi[7], inst_hi[30:25],
                                          inst_hi[11:8], 1'b0}));
            IMM_U:   imm = XLEN'($signed({inst_hi[31:12], 12'b0}));
            IMM_J:   imm = XLEN'($signed({inst_hi[31], inst_hi[19:12], inst_hi[20],
                                          inst_hi[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24090012_idu.sv
// ---------------------------------------------------------------------------
// ysyx_24090012_idu
// Instruction decode stage between IFU and EXU. Decodes one RV32I instruction
// per IFU handshake into a registered bundle offered to the EXU with a second
// valid/ready handshake (latency 1, throughput 1/cycle). Accepting ebreak or
// an illegal encoding moves the stage to HALT, which only rst leaves; the
// triggering bundle is still delivered.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   inst, pc, ifu_valid      IFU request; idu_ready back to IFU
//   exu_valid, exu_ready     EXU handshake
//   exu_pc, rs1, rs2, rd, imm, alu_op, alu_src_imm, alu_src_pc, funct3,
//   mem_ren, mem_wen, rd_wen, is_branch, is_jal, is_jalr, is_ebreak,
//   illegal                  registered decoded bundle
//   halted                   stage is in HALT
//
// Build option: define YSYX_24090012_RV32E_EN to restrict to 16 registers;
// any used register index >= 16 is then decoded as illegal.
// ---------------------------------------------------------------------------
module ysyx_24090012_idu
    import ysyx_24090012_idu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            ifu_valid,
    output logic            idu_ready,
    output logic            exu_valid,
    input  logic            exu_ready,
    output logic [XLEN-1:0] exu_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic            alu_src_pc,
    output logic [2:0]      funct3,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic            rd_wen,
    output logic            is_branch,
    output logic            is_jal,
    output logic            is_jalr,
    output logic            is_ebreak,
    output logic            illegal,
    output logic            halted
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            legal;
    logic            rv32e_bad;
    imm_type_e       imm_type;
    logic [XLEN-1:0] imm_val;
    idu_bundle_t     dec;
    idu_bundle_t     dec_full;

    idu_state_e      state_q, state_d;
    logic            valid_q, valid_d;
    idu_bundle_t     bundle_q, bundle_d;
    logic            accept;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

`ifdef YSYX_24090012_RV32E_EN
    // Which register fields the opcode actually reads/writes: {rd, rs2, rs1}.
    logic [2:0] reg_used;
    logic [2:0] reg_hi;
    logic [4:0] reg_idx [3];

    assign reg_idx[0] = inst[19:15];
    assign reg_idx[1] = inst[24:20];
    assign reg_idx[2] = inst[11:7];

    always_comb begin
        reg_used = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL:    reg_used = 3'b100;
            OPC_JALR, OPC_LOAD, OPC_OPIMM:  reg_used = 3'b101;
            OPC_BRANCH, OPC_STORE:          reg_used = 3'b011;
            OPC_OP:                         reg_used = 3'b111;
            default:                        reg_used = 3'b000;
        endcase
    end

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_rv32e
        assign reg_hi[gi] = reg_used[gi] & reg_idx[gi][4];
    end

    assign rv32e_bad = |reg_hi;
`else
    assign rv32e_bad = 1'b0;
`endif

    // Main decoder. Register fields and funct3 are always raw passthrough;
    // an illegal encoding clears every control bit and the immediate.
    always_comb begin
        dec        = '0;
        imm_type   = IMM_NONE;
        legal      = 1'b1;
        dec.pc     = pc;
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        dec.funct3 = f3;
        case (opcode)
            OPC_LUI: begin
                imm_type        = IMM_U;
                dec.alu_op      = ALU_PASSB;
                dec.alu_src_imm = 1'b1;
                dec.rd_wen      = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type        = IMM_U;
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.alu_src_pc  = 1'b1;
                dec.rd_wen      = 1'b1;
            end
            OPC_JAL: begin
                imm_type        = IMM_J;
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.alu_src_pc  = 1'b1;
                dec.rd_wen      = 1'b1;
                dec.is_jal      = 1'b1;
            end
            OPC_JALR: begin
                legal           = (f3 == 3'b000);
                imm_type        = IMM_I;
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.rd_wen      = 1'b1;
                dec.is_jalr     = 1'b1;
            end
            OPC_BRANCH: begin
                legal           = (f3 != 3'b010) && (f3 != 3'b011);
                imm_type        = IMM_B;
                dec.alu_op      = ALU_SUB;
                dec.is_branch   = 1'b1;
            end
            OPC_LOAD: begin
                legal           = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                imm_type        = IMM_I;
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.mem_ren     = 1'b1;
                dec.rd_wen      = 1'b1;
            end
            OPC_STORE: begin
                legal           = f3 inside {3'b000, 3'b001, 3'b010};
                imm_type        = IMM_S;
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.mem_wen     = 1'b1;
            end
            OPC_OPIMM: begin
                // Only shifts constrain funct7; bit 30 picks SRAI.
                if (f3 == 3'b001)
                    legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                imm_type        = IMM_I;
                dec.alu_op      = alu_from_funct3(f3, f7[5] && (f3 == 3'b101));
                dec.alu_src_imm = 1'b1;
                dec.rd_wen      = 1'b1;
            end
            OPC_OP: begin
                legal      = (f7 == 7'b0000000) ||
                             ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                dec.alu_op = alu_from_funct3(f3, f7[5]);
                dec.rd_wen = 1'b1;
            end
            OPC_SYSTEM: begin
                if (inst == INST_EBREAK)
                    dec.is_ebreak = 1'b1;
                else
                    legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase

        if (rv32e_bad)
            legal = 1'b0;

        if (!legal) begin
            dec         = '0;
            dec.pc      = pc;
            dec.rs1     = inst[19:15];
            dec.rs2     = inst[24:20];
            dec.rd      = inst[11:7];
            dec.funct3  = f3;
            dec.illegal = 1'b1;
            imm_type    = IMM_NONE;
        end

        if (dec.rd == 5'd0)
            dec.rd_wen = 1'b0;
    end

    ysyx_24090012_imm_gen u_imm_gen (
        .inst_hi  (inst[31:7]),
        .imm_type (imm_type),
        .imm      (imm_val)
    );

    always_comb begin
        dec_full     = dec;
        dec_full.imm = imm_val;
    end

    // rst is folded in so the IFU never sees ready during reset.
    assign idu_ready = (state_q == ST_RUN) && !rst && (!valid_q || exu_ready);
    assign accept    = ifu_valid && idu_ready;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (accept) begin
            bundle_d = dec_full;
            valid_d  = 1'b1;
            if (dec_full.illegal || dec_full.is_ebreak)
                state_d = ST_HALT;
        end else if (valid_q && exu_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign exu_valid   = valid_q;
    assign halted      = (state_q == ST_HALT);
    assign exu_pc      = bundle_q.pc;
    assign rs1         = bundle_q.rs1;
    assign rs2         = bundle_q.rs2;
    assign rd          = bundle_q.rd;
    assign imm         = bundle_q.imm;
    assign alu_op      = bundle_q.alu_op;
    assign alu_src_imm = bundle_q.alu_src_imm;
    assign alu_src_pc  = bundle_q.alu_src_pc;
    assign funct3      = bundle_q.funct3;
    assign mem_ren     = bundle_q.mem_ren;
    assign mem_wen     = bundle_q.mem_wen;
    assign rd_wen      = bundle_q.rd_wen;
    assign is_branch   = bundle_q.is_branch;
    assign is_jal      = bundle_q.is_jal;
    assign is_jalr     = bundle_q.is_jalr;
    assign is_ebreak   = bundle_q.is_ebreak;
    assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_ysyx_24090012_idu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24090012_idu
// Scoreboard bench for the decode stage: the driver pushes the reference
// decode of every accepted instruction into a queue; a monitor compares the
// DUT bundle against the queue head whenever exu_valid is high and pops it on
// transfer. Directed cases first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_ysyx_24090012_idu;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        src_imm;
        logic        src_pc;
        logic [2:0]  f3;
        logic        mren;
        logic        mwen;
        logic        rdwen;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ebrk;
        logic        ill;
    } exp_t;

    // ALU code by funct3 for the base (non-alternate) operations.
    localparam int ALU_TAB [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic        ifu_valid = 1'b0;
    logic        exu_ready = 1'b0;
    logic        idu_ready, exu_valid, halted;
    logic [31:0] exu_pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic        alu_src_imm, alu_src_pc;
    logic [2:0]  funct3;
    logic        mem_ren, mem_wen, rd_wen;
    logic        is_branch, is_jal, is_jalr, is_ebreak, illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    logic halted_m = 1'b0;

    always #5 clk = ~clk;

    ysyx_24090012_idu dut (
        .clk(clk), .rst(rst), .inst(inst), .pc(pc),
        .ifu_valid(ifu_valid), .idu_ready(idu_ready),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_pc(exu_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc),
        .funct3(funct3), .mem_ren(mem_ren), .mem_wen(mem_wen), .rd_wen(rd_wen),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .is_ebreak(is_ebreak), .illegal(illegal), .halted(halted)
    );

    function automatic exp_t dut_bundle();
        exp_t a;
        a = {exu_pc, rs1, rs2, rd, imm, alu_op, alu_src_imm, alu_src_pc, funct3,
             mem_ren, mem_wen, rd_wen, is_branch, is_jal, is_jalr, is_ebreak, illegal};
        return a;
    endfunction

    // Reference decode written from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ok;
        logic        wr;
        logic [2:0]  used;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        imm_i = {{20{w[31]}}, w[31:20]};
        imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
        imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        imm_u = {w[31:12], 12'h000};
        imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        e = '0;
        ok = 1'b1;
        wr = 1'b0;
        used = 3'b000;
        case (op)
            7'h37: begin e.alu_op = 4'd10; e.imm = imm_u; e.src_imm = 1; wr = 1; used = 3'b100; end
            7'h17: begin e.imm = imm_u; e.src_imm = 1; e.src_pc = 1; wr = 1; used = 3'b100; end
            7'h6F: begin e.imm = imm_j; e.src_imm = 1; e.src_pc = 1; e.jal = 1; wr = 1; used = 3'b100; end
            7'h67: begin ok = (f3 == 0); e.imm = imm_i; e.src_imm = 1; e.jalr = 1; wr = 1; used = 3'b101; end
            7'h63: begin ok = !(f3 inside {2, 3}); e.imm = imm_b; e.alu_op = 4'd1; e.br = 1; used = 3'b011; end
            7'h03: begin ok = f3 inside {0, 1, 2, 4, 5}; e.imm = imm_i; e.src_imm = 1; e.mren = 1; wr = 1; used = 3'b101; end
            7'h23: begin ok = f3 inside {0, 1, 2}; e.imm = imm_s; e.src_imm = 1; e.mwen = 1; used = 3'b011; end
            7'h13: begin
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
                e.alu_op = 4'(ALU_TAB[f3] + ((f3 == 5 && f7 == 7'h20) ? 1 : 0));
                e.imm = imm_i; e.src_imm = 1; wr = 1; used = 3'b101;
            end
            7'h33: begin
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                e.alu_op = 4'(ALU_TAB[f3] + ((f7 == 7'h20) ? 1 : 0));
                wr = 1; used = 3'b111;
            end
            7'h73: begin ok = (w == 32'h0010_0073); e.ebrk = ok; end
            default: ok = 1'b0;
        endcase
`ifdef YSYX_24090012_RV32E_EN
        if ((used[0] && w[19]) || (used[1] && w[24]) || (used[2] && w[11]))
            ok = 1'b0;
`else
        if (used == 3'b111 && 1'b0) ok = 1'b0;
`endif
        if (!ok) begin
            e = '0;
            e.ill = 1'b1;
        end
        e.rdwen = ok && wr && (w[11:7] != 0);
        e.pc  = p;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        e.f3  = f3;
        return e;
    endfunction

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One cycle of stimulus; inputs settle at +1, checks at +3 (before negedge).
    task automatic step(input logic v, input logic [31:0] w, input logic r);
        logic [31:0] p;
        logic        exp_rdy;
        exp_t        e;
        @(posedge clk);
        #1;
        p = $urandom & 32'hFFFF_FFFC;
        ifu_valid = v;
        inst      = w;
        pc        = p;
        exu_ready = r;
        #2;
        chk("halted", 96'(halted), 96'(halted_m));
        exp_rdy = !halted_m && (expq.size() == 0 || r);
        chk("idu_ready", 96'(idu_ready), 96'(exp_rdy));
        if (v && exp_rdy) begin
            e = model(w, p);
            expq.push_back(e);
            $display("accept inst=%08h pc=%08h ill=%0b ebrk=%0b", w, p, e.ill, e.ebrk);
            if (e.ill || e.ebrk) halted_m = 1'b1;
        end
    endtask

    task automatic do_reset(input logic r_during);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ifu_valid = 1'b0;
        exu_ready = r_during;
        #2;
        chk("ready_in_rst", 96'(idu_ready), 96'(0));
        @(posedge clk);
        #1;
        expq.delete();
        halted_m = 1'b0;
        chk("rst_valid", 96'(exu_valid), 96'(0));
        chk("rst_bundle", 96'(dut_bundle()), 96'(0));
        chk("rst_halted", 96'(halted), 96'(0));
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [10];
        logic [31:0] w;
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k >= 10) return w;
        w[6:0] = ops[k];
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        if (k == 9 && $urandom_range(0, 1) == 1) w = 32'h0010_0073;
        return w;
    endfunction

    // Monitor: compare the presented bundle; pop on transfer.
    always @(negedge clk) begin
        if (!rst && exu_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bundle got=%0h exp=none", dut_bundle());
            end else begin
                if (dut_bundle() !== expq[0]) begin
                    errors++;
                    $display("FAIL bundle got=%0h exp=%0h", dut_bundle(), expq[0]);
                end else begin
                    $display("bundle pc=%08h ok ready=%0b", exu_pc, exu_ready);
                end
                if (exu_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        chk("por_valid", 96'(exu_valid), 96'(0));
        chk("por_bundle", 96'(dut_bundle()), 96'(0));
        chk("por_halted", 96'(halted), 96'(0));
        rst = 1'b0;

        // Directed: addi, sw, beq with backpressure.
        step(1, 32'h0050_0093, 1);
        step(1, 32'h0011_2623, 1);
        step(0, 32'h0, 1);
        step(1, 32'hFE00_0EE3, 0);
        repeat (3) step(1, 32'h0050_0093, 0);
        step(1, 32'h0050_0093, 1);
        step(0, 32'h0, 1);

        // add x16,x0,x16: RV32E-dependent.
        step(1, 32'h0100_0833, 1);
        step(1, 32'h0050_0093, 1);
        step(0, 32'h0, 1);
        do_reset(1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 8, rand_inst(), $urandom_range(0, 9) < 7);
            if (halted_m) begin
                repeat (2) step(1, rand_inst(), $urandom_range(0, 1));
                do_reset($urandom_range(0, 1));
            end
        end

        // ebreak: delivered once, then halted with IFU still offering.
        step(0, 32'h0, 1);
        step(1, 32'h0010_0073, 1);
        repeat (4) step(1, 32'h0050_0093, 1);
        chk("ebreak_drained", 96'(expq.size()), 96'(0));
        chk("ebreak_halted", 96'(halted), 96'(1));

        // Reset while a bundle is stalled.
        do_reset(1);
        step(1, 32'h0050_0093, 0);
        step(1, 32'h0011_2623, 0);
        do_reset(0);
        step(0, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
